// File: rtl/imem_responder.sv
// miniRV instruction-memory responder: fetch handshake, fixed wait states, response handshake.
// Define IMEM_LOAD_PORT_EN to let wr_en_i/wr_addr_i/wr_data_i write the array.
module imem_responder #(
  parameter int          ADDR_W      = 14,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INST    = 32'h00000013
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [31:0]       req_addr_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [31:0]       rsp_inst_o,
  output logic              rsp_err_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [31:0]       wr_data_i
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam bit          NoWait    = (WAIT_CYCLES == 0);
  localparam logic [3:0]  WAIT_INIT = NoWait ? 4'd0 : 4'(WAIT_CYCLES - 1);

  logic [31:0] mem [2**ADDR_W];

  state_t            state;
  logic [3:0]        cnt;
  logic [ADDR_W-1:0] addr_q;
  logic              err_q;

  logic              req_hs;
  logic              req_err;
  logic [ADDR_W-1:0] req_word;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_err;
  logic              go_rsp;
  logic              go_wait;
  logic              go_idle;

  assign req_ready_o = rst_i &
                       ((state == IDLE) |
                        ((state == RESP) & rsp_ready_i));
  assign req_hs   = req_valid_i & req_ready_o;
  assign req_word = req_addr_i[ADDR_W+1:2];
  assign req_err  = (req_addr_i[1:0] != 2'b00) |
                    (|req_addr_i[31:ADDR_W+2]);

  // With no wait states the read happens at the accept edge itself.
  assign rd_addr = NoWait ? req_word : addr_q;
  assign rd_err  = NoWait ? req_err : err_q;

  assign go_rsp  = (req_hs & NoWait) |
                   ((state == WAIT) & (cnt == 4'd0));
  assign go_wait = req_hs & !NoWait;
  assign go_idle = (state == RESP) & rsp_ready_i & !req_hs;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_inst_o  <= NOP_INST;
      rsp_err_o   <= 1'b0;
    end else begin
      if (req_hs) begin
        addr_q <= req_word;
        err_q  <= req_err;
      end
      unique case (1'b1)
        go_rsp: begin
          state       <= RESP;
          rsp_valid_o <= 1'b1;
          rsp_inst_o  <= rd_err ? NOP_INST : mem[rd_addr];
          rsp_err_o   <= rd_err;
        end
        go_wait: begin
          state       <= WAIT;
          cnt         <= WAIT_INIT;
          rsp_valid_o <= 1'b0;
        end
        go_idle: begin
          state       <= IDLE;
          rsp_valid_o <= 1'b0;
        end
        default: begin
          if (state == WAIT) cnt <= cnt - 4'd1;
        end
      endcase
    end
  end

`ifdef IMEM_LOAD_PORT_EN
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
  end
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the miniRV core: the memory-side end of the fetch interface. It accepts word-fetch requests over a valid/ready handshake, waits a configurable number of cycles, then returns the addressed instruction word over a second valid/ready handshake. It lets the fetch stage run against a memory with non-zero latency and backpressure, and it flags misaligned or out-of-range fetches. A debug write port for program loading is optional.

## Interface
Parameters:
- ADDR_W, default 14: word-address width; memory depth is 2^ADDR_W words, indexed by byte address bits [ADDR_W+1:2].
- WAIT_CYCLES, default 2: wait states between request acceptance and response; legal range 0..15.
- NOP_INST, default 32'h00000013: word returned on error and driven on rsp_inst_o at reset.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- req_valid_i  in  1  fetch request valid.
- req_ready_o  out  1  responder can accept a request this cycle.
- req_addr_i  in  32  fetch byte address.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  consumer accepts the response this cycle.
- rsp_inst_o  out  32  instruction word.
- rsp_err_o  out  1  request was misaligned or out of range.
- wr_en_i  in  1  load-port write enable.
- wr_addr_i  in  ADDR_W  load-port word address.
- wr_data_i  in  32  load-port write data.

## Operation
- Storage is an internal array of 2^ADDR_W 32-bit words, with no reset of its contents.
- The block has three states: IDLE, WAIT and RESP.
- req_ready_o = (state==IDLE) | (state==RESP & rsp_ready_i), and is forced to 0 while rst_i==0.
- A request handshake (req_valid_i & req_ready_o) does three things:
  - latches the address;
  - evaluates the error condition: req_addr_i[1:0]!=0, or any bit of req_addr_i[31:ADDR_W+2] nonzero;
  - moves to WAIT with counter = WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES==0.
- In WAIT, the counter decrements each cycle; at 0 the next edge moves to RESP.
- On entry to RESP, rsp_inst_o and rsp_err_o are registered:
  - error: NOP_INST and 1;
  - otherwise: mem[latched word address] and 0.
- In RESP, rsp_valid_o=1. rsp_inst_o and rsp_err_o stay stable until rsp_ready_i=1.
- On a RESP handshake:
  - with a simultaneous new request, the new request is accepted (back-to-back), and the next state is WAIT, or RESP when WAIT_CYCLES==0;
  - otherwise, the next state is IDLE.
- rsp_valid_o is 0 in IDLE and WAIT.
- Reset values: state IDLE, rsp_valid_o=0, rsp_inst_o=NOP_INST, rsp_err_o=0, counter=0; req_ready_o=0 while reset is held and 1 in the first cycle after release.
- Reset mid-operation: any latched or pending request is dropped and no response is produced for it.
- Read/write collision: the read is performed at the edge entering RESP. A write to the same word at that same edge returns the old data; a write at any earlier edge is visible.
- req_addr_i is sampled only at the handshake; later changes are ignored.

## Timing
- Request handshake in cycle c: rsp_valid_o first high in cycle c+1+WAIT_CYCLES.
- WAIT_CYCLES=0: one-cycle latency.
- Sustained throughput is one response per 1+WAIT_CYCLES cycles when rsp_ready_i is held high and requests are back-to-back.
- Load-port writes take effect at the clock edge where wr_en_i=1, with no handshake.

## Configuration
- Macro IMEM_LOAD_PORT_EN.
- Defined: wr_en_i, wr_addr_i and wr_data_i write the array, in any state, at any cycle.
- Undefined: the ports remain present but are ignored, and no write logic is synthesized. The array contents then come only from simulation/FPGA initialisation.

## Test plan
- Reset: hold rst_i=0 for 3 cycles with req_valid_i=1 -> req_ready_o=0, rsp_valid_o=0, rsp_inst_o=32'h00000013, rsp_err_o=0; req_ready_o=1 in the first cycle after release.
- Single fetch, WAIT_CYCLES=2, mem[2]=32'h00500093, request 0x00000008 in cycle c -> rsp_valid_o rises in cycle c+3 with rsp_inst_o=32'h00500093 and rsp_err_o=0; back to IDLE after rsp_ready_i.
- Backpressure: rsp_ready_i=0 for 5 cycles during RESP -> rsp_valid_o stays 1, data is unchanged, req_ready_o=0; a new request is accepted in the same cycle rsp_ready_i rises.
- Errors: request 0x00000006 -> rsp_err_o=1, rsp_inst_o=32'h00000013; with ADDR_W=14, request 0x00010000 -> rsp_err_o=1.
- Load port (macro defined): write 32'hDEADBEEF to word 4, then fetch 0x10 -> returns 32'hDEADBEEF. Same test with the macro undefined -> the original contents are returned.
- Reset during WAIT (WAIT_CYCLES=4, reset asserted 2 cycles after acceptance) -> no rsp_valid_o pulse ever appears for that request, and a fresh request afterwards completes normally.
